// File: rtl/vram_writer_if.sv
// Purpose: store-request bus from the vector CPU into vram_writer.
// Latency: none (wires only); the slave drives req_ready from registered state.
// Backpressure: master holds req_valid/addr/data/mask until req_ready is seen high at a clock edge.
//   req_valid : store request valid             (master -> slave)
//   req_ready : request FIFO has a free entry   (slave  -> master)
//   req_addr  : base pixel address, lane i targets req_addr+i
//   req_data  : lane i at [i*DATA_W +: DATA_W]
//   req_mask  : lane i written only when bit i is set
interface vram_writer_if #(
    parameter int ADDR_W = 17,
    parameter int LANES  = 6,
    parameter int DATA_W = 8
);
    logic                     req_valid;
    logic                     req_ready;
    logic [ADDR_W-1:0]        req_addr;
    logic [LANES*DATA_W-1:0]  req_data;
    logic [LANES-1:0]         req_mask;

    modport master (output req_valid, req_addr, req_data, req_mask, input req_ready);
    modport slave  (input req_valid, req_addr, req_data, req_mask, output req_ready);
endinterface

// File: rtl/vram_writer.sv
// Purpose: buffer 6-lane vector stores and serialise them into byte writes on the frame-buffer port.
// Latency: accept at edge T into an idle, empty engine -> lane-0 write visible after edge T+2; LANES slots per request.
// Backpressure: req_ready = FIFO not full (registered state only); hold_i blocks starting new requests.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   req               : store-request bus (slave modport)
//   hold_i            : inhibit popping the next request (current one always finishes)
//   we_o/a_o/d_o      : registered frame-buffer write enable/address/data
//   oob_o             : pulse, masked-in lane dropped because its address is past the frame buffer
//   done_o            : pulse aligned with the last lane's output slot
//   busy_o            : registered, work queued or in flight
module vram_writer #(
    parameter int ADDR_W  = 17,
    parameter int LANES   = 6,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int FB_SIZE = 76800
) (
    input  logic              clk,
    input  logic              rst_n,
    vram_writer_if.slave      req,
    input  logic              hold_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] a_o,
    output logic [DATA_W-1:0] d_o,
    output logic              oob_o,
    output logic              done_o,
    output logic              busy_o
);
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    localparam logic [ADDR_W:0]   LP_FB_SIZE = (ADDR_W+1)'(FB_SIZE);
    localparam logic [LANE_W-1:0] LP_LAST    = LANE_W'(LANES - 1);
    localparam logic [CNT_W-1:0]  LP_DEPTH   = CNT_W'(DEPTH);

    typedef enum logic {S_IDLE, S_WRITE} state_t;

    // request FIFO
    logic [ADDR_W-1:0]       r_fifo_addr [DEPTH];
    logic [LANES*DATA_W-1:0] r_fifo_data [DEPTH];
    logic [LANES-1:0]        r_fifo_mask [DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [CNT_W-1:0]        r_count;
    logic [CNT_W-1:0]        w_count_nxt;

    // working register for the request being serialised
    logic [ADDR_W-1:0]       r_wk_addr;
    logic [LANES*DATA_W-1:0] r_wk_data;
    logic [LANES-1:0]        r_wk_mask;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [LANE_W-1:0]       r_lane;
    logic [LANE_W-1:0]       w_lane_nxt;

    logic                    w_ready;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_can_pop;
    logic                    w_last;
    logic [ADDR_W:0]         w_ea;
    logic                    w_lane_on;
    logic                    w_in_range;
    logic                    w_slot_we;
    logic                    w_slot_oob;
    logic                    w_slot_done;
    logic [DATA_W-1:0]       w_lane_dat;

    logic                    r_we;
    logic [ADDR_W-1:0]       r_a;
    logic [DATA_W-1:0]       r_d;
    logic                    r_oob;
    logic                    r_done;
    logic                    r_busy;

    assign w_ready       = (r_count < LP_DEPTH);
    assign req.req_ready = w_ready;
    assign w_push        = req.req_valid && w_ready;
    assign w_can_pop     = (r_count != '0) && !hold_i;
    assign w_last        = (r_lane == LP_LAST);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_lane  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_lane  <= w_lane_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        w_lane_nxt  = r_lane;
        case (r_state)
            S_IDLE: begin
                if (w_can_pop) begin
                    w_state_nxt = S_WRITE;
                    w_lane_nxt  = '0;
                end
            end
            S_WRITE: begin
                if (w_last) begin
                    // Chain straight into the next request so a full FIFO drains with no bubble.
                    w_lane_nxt  = '0;
                    w_state_nxt = w_can_pop ? S_WRITE : S_IDLE;
                end else begin
                    w_lane_nxt = r_lane + LANE_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_lane_nxt  = '0;
            end
        endcase
    end

    // ---------------- FSM: outputs (slot decode) ----------------
    always_comb begin
        w_pop       = w_can_pop && ((r_state == S_IDLE) || w_last);
        // Extra top bit keeps addresses past 2^ADDR_W from wrapping back into range.
        w_ea        = {1'b0, r_wk_addr} + {{(ADDR_W+1-LANE_W){1'b0}}, r_lane};
        w_lane_on   = r_wk_mask[r_lane];
        w_in_range  = (w_ea < LP_FB_SIZE);
        w_lane_dat  = r_wk_data[r_lane*DATA_W +: DATA_W];
        w_slot_we   = (r_state == S_WRITE) && w_lane_on && w_in_range;
        w_slot_oob  = (r_state == S_WRITE) && w_lane_on && !w_in_range;
        w_slot_done = (r_state == S_WRITE) && w_last;
    end

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // FIFO storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= req.req_addr;
            r_fifo_data[r_wr_ptr] <= req.req_data;
            r_fifo_mask[r_wr_ptr] <= req.req_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_wk_addr <= '0;
            r_wk_data <= '0;
            r_wk_mask <= '0;
        end else begin
            r_count <= w_count_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
                r_wk_addr <= r_fifo_addr[r_rd_ptr];
                r_wk_data <= r_fifo_data[r_rd_ptr];
                r_wk_mask <= r_fifo_mask[r_rd_ptr];
            end
        end
    end

    // Write-port registers; address/data only move on a real write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we   <= 1'b0;
            r_a    <= '0;
            r_d    <= '0;
            r_oob  <= 1'b0;
            r_done <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_we   <= w_slot_we;
            r_oob  <= w_slot_oob;
            r_done <= w_slot_done;
            if (w_slot_we) begin
                r_a <= w_ea[ADDR_W-1:0];
                r_d <= w_lane_dat;
            end
            // Uses next-state values so busy rises right after the accepting edge, and stays
            // up through the registered output slot of the final lane.
            r_busy <= (w_count_nxt != '0) || (w_state_nxt == S_WRITE) || (r_state == S_WRITE);
        end
    end

    assign we_o   = r_we;
    assign a_o    = r_a;
    assign d_o    = r_d;
    assign oob_o  = r_oob;
    assign done_o = r_done;
    assign busy_o = r_busy;
endmodule

// File: tb/tb_vram_writer.sv
module tb_vram_writer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        hold_i;
    logic        we_o;
    logic [16:0] a_o;
    logic [7:0]  d_o;
    logic        oob_o;
    logic        done_o;
    logic        busy_o;
    int          cyc = 0;

    vram_writer_if #(.ADDR_W(17), .LANES(6), .DATA_W(8)) req_if();

    vram_writer #(.ADDR_W(17), .LANES(6), .DATA_W(8), .DEPTH(4), .FB_SIZE(76800)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_if),
        .hold_i (hold_i),
        .we_o   (we_o),
        .a_o    (a_o),
        .d_o    (d_o),
        .oob_o  (oob_o),
        .done_o (done_o),
        .busy_o (busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic        we;
        logic        oob;
        logic        done;
        logic [16:0] a;
        logic [7:0]  d;
    } ev_t;
    typedef struct { int w; int o; } cnt_t;
    typedef struct {
        logic [16:0] addr;
        logic [47:0] data;
        logic [5:0]  mask;
        int          exp_w;
        int          exp_o;
    } vec_t;

    vec_t  tbl [6];
    ev_t   exp_q [$];
    cnt_t  cnt_q [$];
    int    done_cyc_q [$];
    int    n_vec = 0;
    int    n_err = 0;
    int    cur_w = 0;
    int    cur_o = 0;
    int    n_we = 0;
    int    n_done = 0;
    int    n_sent = 0;
    int    stall_at = -1;
    bit    mon_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Reference model: expected observable events of one request, in order.
    task automatic push_exp(input int idx);
        logic [17:0] ea;
        ev_t  e;
        cnt_t c;
        for (int i = 0; i < 6; i++) begin
            ea     = {1'b0, tbl[idx].addr} + 18'(i);
            e.we   = tbl[idx].mask[i] && (ea < 18'd76800);
            e.oob  = tbl[idx].mask[i] && !(ea < 18'd76800);
            e.done = (i == 5);
            e.a    = ea[16:0];
            e.d    = tbl[idx].data[i*8 +: 8];
            if (e.we || e.oob || e.done) exp_q.push_back(e);
        end
        c.w = tbl[idx].exp_w;
        c.o = tbl[idx].exp_o;
        cnt_q.push_back(c);
    endtask

    task automatic monitor();
        ev_t  e;
        cnt_t c;
        forever begin
            @(negedge clk);
            if (we_o) n_we++;
            if (mon_en && (we_o || oob_o || done_o)) begin
                if (we_o)  cur_w++;
                if (oob_o) cur_o++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", {we_o, oob_o, done_o}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("slot", 64'({we_o, oob_o, done_o, e.we ? a_o : 17'd0, e.we ? d_o : 8'd0}),
                               64'({e.we, e.oob, e.done, e.we ? e.a : 17'd0, e.we ? e.d : 8'd0}));
                end
                if (done_o) begin
                    n_done++;
                    done_cyc_q.push_back(cyc);
                    if (cnt_q.size() == 0) begin
                        chk("unexpected_done", 64'd1, 64'd0);
                    end else begin
                        c = cnt_q.pop_front();
                        chk("lane_counts", {32'(cur_w), 32'(cur_o)}, {32'(c.w), 32'(c.o)});
                    end
                    cur_w = 0;
                    cur_o = 0;
                end
            end
        end
    endtask

    // Drive one table entry; returns after the accepting edge (+1) with its cycle number.
    task automatic send(input int idx, output int acc_c);
        int t;
        t = 0;
        acc_c = 0;
        req_if.req_valid = 1'b1;
        req_if.req_addr  = tbl[idx].addr;
        req_if.req_data  = tbl[idx].data;
        req_if.req_mask  = tbl[idx].mask;
        while (!req_if.req_ready && t < 200) begin
            if (stall_at < 0) stall_at = n_sent;
            @(posedge clk); #1;
            t++;
        end
        if (t >= 200) begin
            chk("accept_timeout", 64'd0, 64'd1);
            req_if.req_valid = 1'b0;
            return;
        end
        push_exp(idx);
        @(posedge clk); #1;
        acc_c = cyc;
        n_sent++;
    endtask

    task automatic wait_idle(input int budget);
        int t;
        for (t = 0; t < budget; t++) begin
            @(negedge clk); #1;
            if (!busy_o) break;
        end
        chk("idle_within_budget", 64'(t < budget), 64'd1);
    endtask

    task automatic wait_write_at(input logic [16:0] addr, input int budget);
        int t;
        for (t = 0; t < budget; t++) begin
            @(negedge clk);
            if (we_o && a_o == addr) break;
        end
        chk("write_seen", 64'(t < budget), 64'd1);
    endtask

    initial begin
        int acc, t, n0, d0;
        tbl[0] = '{17'd100,    48'h665544332211, 6'b111111, 6, 0};
        tbl[1] = '{17'd0,      48'hF6E5D4C3B2A1, 6'b010101, 3, 0};
        tbl[2] = '{17'd76797,  48'h0102030405AA, 6'b111111, 3, 3};
        tbl[3] = '{17'd131070, 48'h123456789ABC, 6'b111111, 0, 6};
        tbl[4] = '{17'd76799,  48'hDEADBEEFCAFE, 6'b100001, 1, 1};
        tbl[5] = '{17'd500,    48'h5A5A5A5A5A5A, 6'b000000, 0, 0};

        rst_n = 1'b0;
        hold_i = 1'b0;
        req_if.req_valid = 1'b0;
        req_if.req_addr  = '0;
        req_if.req_data  = '0;
        req_if.req_mask  = '0;
        fork monitor(); join_none

        #3;
        chk("rst_flags", {60'd0, we_o, oob_o, done_o, busy_o}, 64'd0);
        chk("rst_a", 64'(a_o), 64'd0);
        chk("rst_d", 64'(d_o), 64'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", 64'(req_if.req_ready), 64'd1);
        chk("busy_after_rst", 64'(busy_o), 64'd0);

        // Single store: latency, 6 consecutive writes, done on last, busy window.
        send(0, acc);
        req_if.req_valid = 1'b0;
        chk("busy_after_accept", 64'(busy_o), 64'd1);
        for (t = 0; t < 10; t++) begin
            @(negedge clk);
            if (we_o) break;
        end
        chk("first_write_latency", 64'(cyc - acc), 64'd2);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            chk("run_we_done", {62'd0, we_o, done_o}, {62'd0, 1'b1, k == 5});
        end
        chk("busy_on_done", 64'(busy_o), 64'd1);
        @(negedge clk);
        chk("busy_after_done", 64'(busy_o), 64'd0);

        // Table vectors one at a time.
        for (int i = 1; i < 6; i++) begin
            send(i, acc);
            req_if.req_valid = 1'b0;
            wait_idle(50);
        end
        chk("drain_single", 64'(exp_q.size()), 64'd0);

        // Back-to-back burst of all six: FIFO fills, no bubbles, order kept.
        done_cyc_q.delete();
        n_sent = 0;
        stall_at = -1;
        for (int i = 0; i < 6; i++) send(i, acc);
        req_if.req_valid = 1'b0;
        chk("accepts_before_full", 64'(stall_at), 64'd5);
        wait_idle(100);
        chk("burst_dones", 64'(done_cyc_q.size()), 64'd6);
        if (done_cyc_q.size() == 6)
            for (int k = 0; k < 5; k++)
                chk("done_spacing", 64'(done_cyc_q[k+1] - done_cyc_q[k]), 64'd6);
        chk("drain_burst", 64'(exp_q.size()), 64'd0);

        // Hold before start: nothing written while held.
        hold_i = 1'b1;
        send(0, acc);
        send(2, acc);
        req_if.req_valid = 1'b0;
        n0 = n_we;
        repeat (10) @(negedge clk);
        #1;
        chk("hold_no_write", 64'(n_we - n0), 64'd0);
        chk("hold_busy", 64'(busy_o), 64'd1);
        hold_i = 1'b0;
        wait_idle(100);
        chk("drain_hold", 64'(exp_q.size()), 64'd0);

        // Hold raised during lane 2: current request finishes, next one waits.
        send(0, acc);
        send(1, acc);
        req_if.req_valid = 1'b0;
        wait_write_at(17'd100, 20);
        @(posedge clk); #1;
        hold_i = 1'b1;
        d0 = n_done;
        repeat (20) @(negedge clk);
        #1;
        chk("hold_mid_done", 64'(n_done - d0), 64'd1);
        chk("hold_mid_busy", 64'(busy_o), 64'd1);
        chk("hold_mid_pending", 64'(exp_q.size()), 64'd4);
        hold_i = 1'b0;
        wait_idle(100);
        chk("drain_hold_mid", 64'(exp_q.size()), 64'd0);

        // Reset during lane 3 with two requests queued.
        send(0, acc);
        send(2, acc);
        send(4, acc);
        req_if.req_valid = 1'b0;
        wait_write_at(17'd102, 20);
        mon_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_flags", {60'd0, we_o, oob_o, done_o, busy_o}, 64'd0);
        chk("midrst_ad", {39'd0, a_o, d_o}, 64'd0);
        exp_q.delete();
        cnt_q.delete();
        cur_w = 0;
        cur_o = 0;
        @(posedge clk);
        @(negedge clk); #2;
        rst_n = 1'b1;
        mon_en = 1'b1;
        n0 = n_we;
        repeat (20) @(negedge clk);
        #1;
        chk("postrst_no_write", 64'(n_we - n0), 64'd0);
        chk("postrst_busy", 64'(busy_o), 64'd0);
        chk("postrst_ready", 64'(req_if.req_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/vram_writer.md
Name: vram_writer

Overview:
- Write-side engine for the byte-wide frame buffer that the VGA scan-out path reads through its 17-bit pixel address.
- Accepts 6-lane vector stores (6 x 8-bit, one lane per pixel) from the vector CPU over a valid/ready handshake.
- Buffers the stores in a small FIFO and serialises each one into single-byte writes on the frame-buffer write port, one lane per cycle.
- Honours per-lane byte masks, suppresses out-of-range addresses, and can be held off (e.g. during active display) to avoid tearing.

Parameters:
- ADDR_W, 17, frame-buffer address width.
- LANES, 6, pixels per vector store.
- DATA_W, 8, bits per pixel/lane.
- DEPTH, 4, request FIFO entries (power of two).
- FB_SIZE, 76800, number of valid frame-buffer addresses (320x240); valid range is 0..FB_SIZE-1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  store request valid.
- req_ready  out  1  FIFO can accept a request.
- req_addr  in  ADDR_W  base pixel address; lane i targets req_addr+i.
- req_data  in  LANES*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W].
- req_mask  in  LANES  lane i is written only if bit i = 1.
- hold_i  in  1  when high, no new request is started; the current request completes.
- we_o  out  1  frame-buffer write enable, registered.
- a_o  out  ADDR_W  write address, registered.
- d_o  out  DATA_W  write data, registered.
- oob_o  out  1  one-cycle pulse: a masked-in lane was suppressed for address >= FB_SIZE.
- done_o  out  1  one-cycle pulse in the cycle of a request's last lane slot.
- busy_o  out  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - FIFO emptied (count=0, pointers=0); FSM to IDLE; lane counter=0.
  - we_o=0, a_o=0, d_o=0, oob_o=0, done_o=0, busy_o=0.
  - req_ready=1 in the first cycle after release.
  - Reset mid-request discards the request in flight and all queued requests; no partial writes after reset asserts.
- Handshake:
  - req_ready = (count < DEPTH), derived from registered state only, never from req_valid.
  - Push on rising edge when req_valid && req_ready; {addr, data, mask} are captured.
  - When full, a push is impossible even if a pop occurs in the same cycle.
  - Simultaneous push and pop with 0 < count < DEPTH leaves count unchanged.
- FSM, two states:
  - IDLE: if count > 0 and !hold_i, pop the head into the working register, set lane=0, go to WRITE. Otherwise stay.
  - WRITE: one lane slot per cycle, lane 0..LANES-1, always LANES cycles per request. Masked-out lanes are slot-consuming bubbles.
  - At lane = LANES-1: if count > 0 and !hold_i, pop the next request and restart at lane 0 with no bubble; otherwise go to IDLE.
- Per lane slot:
  - ea = req_addr + lane, computed in ADDR_W+1 bits; no wrap-around.
  - If mask[lane] && ea < FB_SIZE: we_o=1, a_o=ea[ADDR_W-1:0], d_o=lane data.
  - If mask[lane] && ea >= FB_SIZE: we_o=0, oob_o=1.
  - If !mask[lane]: we_o=0, oob_o=0.
  - a_o/d_o hold their last values when we_o=0.
- Outputs are registered one cycle after the FSM slot.
  - Accept at edge T with an empty FIFO in IDLE: pop at edge T+1, lane-0 write visible after edge T+2.
  - done_o is aligned with the lane-(LANES-1) output slot.
- hold_i is sampled only at pop decisions; asserting it mid-request never stalls lanes already started.
- busy_o is registered: high from the cycle after the accepting edge until the cycle after the final lane slot, with an empty FIFO.
- Sustained throughput: one request per LANES cycles. The FIFO only fills if the producer exceeds that rate.

Test Plan:
- Single store: addr=100, data lanes 0x11..0x66, mask=6'b111111, hold_i=0 -> we_o high 6 consecutive cycles starting 2 cycles after accept; a_o=100..105; d_o=0x11..0x66; done_o on the a_o=105 cycle; oob_o never.
- Mask: addr=0, mask=6'b010101 -> writes only a_o=0, 2, 4 (d_o=lanes 0, 2, 4); 6 slots total; done_o after slot 5.
- Boundary: addr=76797, mask all 1 -> writes 76797..76799; oob_o pulses on slots 3, 4, 5; addr=131070 -> all 6 lanes oob, no we_o, no wrap to 0.
- Back-to-back and full: present 6 requests continuously -> req_ready drops after 5 accepts (4 queued + 1 popped at the following edge); 36 contiguous slots with no bubble between requests; order preserved.
- hold_i: queue 2 requests with hold_i=1 -> no we_o and busy_o=1; release hold_i -> writes resume. Asserting hold_i during lane 2 -> that request completes, the next is not started.
- Reset mid-op: rst_n low during lane 3 with 2 queued -> outputs 0 immediately; after release, no writes, busy_o=0, req_ready=1.
